uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmit serializer between NREQ byte-stream requesters,
//  for example the PDM sample streamer and the command/echo path.
//  - Grants whole packets in round-robin order; a packet ends on req_last or after MAX_PKT bytes.
//  - Holds one registered output byte towards the serializer.
//  - Honours host flow control (hold), in the same manner as the loopback rx_hold.
// PARAMETERS
//  NREQ     2    number of requesters, 2..8
//  MAX_PKT  64   bytes per grant before forced release, 1..255
// PORTS
//  clk         in   1        system clock (12 MHz)
//  resetn      in   1        asynchronous active-low reset
//  hold        in   1        1 = pause: no new grants, no new bytes accepted
//  req_valid   in   NREQ     requester i has a byte
//  req_data    in   8*NREQ   byte of requester i at [8*i+:8]
//  req_last    in   NREQ     byte of requester i is the last byte of its packet
//  req_ready   out  NREQ     byte of requester i accepted this cycle (valid&ready)
//  tx_valid    out  1        output byte register full
//  tx_data     out  8        output byte
//  tx_ready    in   1        serializer takes tx_data this cycle (valid&ready)
//  grant       out  NREQ     one-hot current owner; all zero when IDLE
//  busy        out  1        state != IDLE or tx_valid
// BEHAVIOUR
//  Reset values (asynchronous, resetn=0):
//   - state=IDLE, grant=0, tx_valid=0, tx_data=8'h00, byte count=0.
//   - last_owner=NREQ-1, so requester 0 wins the first grant.
//  States:
//   - IDLE: if !hold and any req_valid, pick the first valid requester after
//     last_owner (cyclic). Register grant, clear the count, go to SEND next cycle.
//     Arbitration costs 1 cycle. A hold=1 or all-zero req_valid keeps IDLE.
//   - SEND: req_ready[i] = grant[i] & !hold & (!tx_valid | tx_ready). This is
//     combinational from tx_valid/tx_ready/hold only, never from req_valid.
//     - On accept: tx_data<=req_data[i], tx_valid<=1, count<=count+1.
//     - Release: if the accepted byte has req_last=1, or count+1==MAX_PKT, then
//       grant<=0, last_owner<=i, go to IDLE.
//     - Otherwise stay in SEND. An owner with req_valid=0 keeps the grant (no timeout).
//  Output register:
//   - tx_valid clears when tx_ready=1 and no new byte is accepted the same cycle.
//   - Simultaneous drain and accept keeps tx_valid=1 and loads the new byte, so a
//     back-to-back stream runs at 1 byte/cycle.
//   - tx_data is stable while tx_valid=1 and tx_ready=0.
//  hold:
//   - hold never retracts a full output register; tx_valid stays 1 until the serializer takes it.
//   - hold=1 in SEND keeps the grant and only blocks accepts.
//  Release and re-grant:
//   - After a release the next grant goes to the next requester in order, so a
//     single requester cannot own the serializer for two packets in a row while
//     others are waiting.
//   - A lone active requester is re-granted after a 1-cycle IDLE gap.
//  Counter: 8-bit count, never wraps; the MAX_PKT compare forces release first.
//  Reset mid-packet: the partial packet and the buffered byte are discarded and
//   tx_valid drops immediately. The requester must restart its packet.
//  grant is always one-hot or zero (assertion); req_ready is never set for a non-owner.
// TESTING
//  - Reset: resetn=0 with req_valid=2'b11 -> tx_valid=0, grant=0, req_ready=0;
//    after release, first grant=2'b01.
//  - Round robin: both requesters send a 3-byte packet ("ABC" / "xyz", last on 3rd),
//    tx_ready=1 -> serializer sees A,B,C,x,y,z; grant 01 then 10; 1 idle cycle between.
//  - Forced release: MAX_PKT=4, req0 streams 10 bytes with no last, req1 sends "Q"+last
//    -> serializer sees 4 bytes of req0, then Q, then the next 4 bytes of req0.
//  - Backpressure: tx_ready=0 for 20 cycles mid-packet -> tx_data holds its value,
//    req_ready=0, no byte lost or duplicated; resume gives the exact byte sequence.
//  - hold: assert hold with tx_valid=1 -> the byte still drains, no further accepts,
//    IDLE issues no grant; deassert -> transfer resumes from the next byte.
//  - Reset mid-op: resetn pulse after 2 of 5 bytes -> tx_valid=0 at once; the
//    retransmitted packet arrives complete and in order.
//  - Full-rate run: rs232 serializer with PERIOD=1250 (9600 baud) sends "12" from
//    req0 and "34" from req1 -> tx line decodes "1234".

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet round-robin arbiter sharing one UART transmit serializer
//
// Purpose:
//   Lets NREQ byte-stream requesters share a single UART transmit serializer.
//   Ownership is granted per packet in round-robin order. A packet ends on
//   req_last or after MAX_PKT bytes. One registered output byte faces the
//   serializer. The host hold input pauses new grants and new byte accepts.
//
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   hold       1 = no new grants, no new bytes accepted
//   req_valid  per-requester byte available
//   req_data   per-requester byte, requester i at [8*i+:8]
//   req_last   per-requester last-byte-of-packet flag
//   req_ready  per-requester byte accepted this cycle (valid & ready)
//   tx_valid   output byte register full
//   tx_data    output byte
//   tx_ready   serializer takes tx_data this cycle
//   grant      one-hot current owner, zero when idle
//   busy       arbiter owns a packet or output register full
module uart_tx_arbiter #(
  parameter int NREQ    = 2,
  parameter int MAX_PKT = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              hold,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int         IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] LAST_CNT = 8'(MAX_PKT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic [IW-1:0]   owner_idx;
  logic [7:0]      sel_data;
  logic            sel_last;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_grant;
  logic            slot_open;
  logic            accept;

  // Decode the current owner; grant_q is one-hot in SEND.
  always_comb begin
    owner_idx = '0;
    sel_data  = 8'h00;
    sel_last  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_q[k]) begin
        owner_idx = IW'(k);
        sel_data  = req_data[8*k +: 8];
        sel_last  = req_last[k];
      end
    end
  end

  // Round-robin pick: first valid requester strictly after last_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_grant = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!pick_found && ((int'(last_q) + k) % NREQ == j) && req_valid[j]) begin
          pick_found    = 1'b1;
          pick_idx      = IW'(j);
          pick_grant    = '0;
          pick_grant[j] = 1'b1;
        end
      end
    end
  end

  // The ready window never looks at req_valid, so requesters may wait on it.
  assign slot_open = (state_q == S_SEND) && !hold && (!tx_valid_q || tx_ready);
  assign req_ready = grant_q & {NREQ{slot_open}};
  assign accept    = |(req_ready & req_valid);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    // A drained register empties unless refilled below in the same cycle.
    tx_valid_d = tx_valid_q && !tx_ready;
    tx_data_d  = tx_data_q;

    case (state_q)
      S_IDLE: begin
        if (!hold && pick_found) begin
          grant_d = pick_grant;
          cnt_d   = 8'h00;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (accept) begin
          tx_data_d  = sel_data;
          tx_valid_d = 1'b1;
          cnt_d      = cnt_q + 8'h01;
          // Forced release at MAX_PKT keeps the counter from ever wrapping.
          if (sel_last || (cnt_q == LAST_CNT)) begin
            grant_d = '0;
            last_d  = owner_idx;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_q     <= IW'(NREQ - 1);
      cnt_q      <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign grant    = grant_q;
  assign busy     = (state_q != S_IDLE) || tx_valid_q;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!resetn) $onehot0(grant_q));
  a_ready_owner   : assert property (@(posedge clk) disable iff (!resetn) (req_ready & ~grant_q) == '0);

endmodule
